// File: rtl/uart_defs_pkg.sv
// Shared UART definitions, used by the transmitter now and the matching
// receiver later.
//   uart_state_t      : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   PARITY_*          : values accepted by the PARITY_MODE parameter
//   parity_bit()      : parity of a character for a given parity mode
//   UART_PARAM_CHECK  : generate-scope macro that stops elaboration on an
//                       illegal parameter set
`ifndef UART_DEFS_PKG_SV
`define UART_DEFS_PKG_SV

`define UART_PARAM_CHECK(CPB, DB, PM, SB) \
  if ((CPB) < 2 || (DB) < 5 || (DB) > 9 || (PM) < 0 || (PM) > 2 || \
      (SB) < 1 || (SB) > 2) begin : g_param_check \
    $error("uart: illegal parameter set (CLKS_PER_BIT>=2, DATA_BITS 5..9, PARITY_MODE 0..2, STOP_BITS 1..2)"); \
  end

package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower characters; the extra zeros do not change
  // the XOR. Even parity is the plain XOR, odd parity its inverse.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int mode);
    parity_bit = (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

`endif

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the UART.
//   Clk     : system clock
//   Reset   : synchronous, active-high
//   en      : count while high; the count is held at 0 while low
//   bit_end : high during the last cycle of each bit period
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic bit_end
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset || !en)     cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/param_uart_tx.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits; every bit lasts CLKS_PER_BIT
// clocks.
//   Clk          : system clock
//   Reset        : synchronous, active-high; aborts a frame in progress
//   Tx_Data      : character, sampled only on the accept edge
//   Tx_DataValid : producer has a character
//   Tx_Ready     : block can accept a character (registered)
//   Tx           : serial line, idle high (registered)
//   Tx_Busy      : frame in progress
//   TxDone       : one-cycle pulse on the edge that ends the frame
module param_uart_tx
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_DataValid,
  output logic                 Tx_Ready,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 TxDone
);

  `UART_PARAM_CHECK(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS)

  localparam int                  BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 baud_en;
  logic                 bit_end;

  // The baud counter sits at 0 in IDLE, so the first bit period starts
  // cleanly on the accept edge.
  assign baud_en = (state != ST_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (baud_en),
    .bit_end (bit_end)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      Tx       <= 1'b1;
      Tx_Ready <= 1'b1;
      Tx_Busy  <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Tx_DataValid && Tx_Ready) begin
            shreg    <= Tx_Data;
            // Parity is taken here because the shift register is consumed
            // as the data bits go out.
            par      <= parity_bit(MAX_DATA_BITS'(Tx_Data), PARITY_MODE);
            bit_cnt  <= '0;
            Tx       <= 1'b0;
            Tx_Ready <= 1'b0;
            Tx_Busy  <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            Tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                Tx    <= par;
                state <= ST_PARITY;
              end else begin
                Tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              Tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            Tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt  <= '0;
              Tx       <= 1'b1;
              Tx_Ready <= 1'b1;
              Tx_Busy  <= 1'b0;
              TxDone   <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          Tx       <= 1'b1;
          Tx_Ready <= 1'b1;
          Tx_Busy  <= 1'b0;
          bit_cnt  <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_uart_tx.sv
// Bench for param_uart_tx: four instances (8N1, 8E1, 8O1, 7N2, all at four
// clocks per bit) driven with directed and random characters. Expected line
// waveforms come from a frame built as a list of bit values.
module tb_param_uart_tx;

  localparam int CPB = 4;
  localparam int DB[4] = '{8, 8, 8, 7};
  localparam int PM[4] = '{0, 2, 1, 0};
  localparam int SB[4] = '{1, 1, 1, 2};

  localparam int M_NORM  = 0;
  localparam int M_B2B   = 1;
  localparam int M_PULSE = 2;
  localparam int M_RST   = 3;

  logic            clk;
  logic [3:0]      rst;
  logic [3:0]      vld;
  logic [2:0][7:0] dat;
  logic [6:0]      dat7;
  logic [3:0]      rdy, tx, busy, done;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .Clk(clk), .Reset(rst[0]), .Tx_Data(dat[0]), .Tx_DataValid(vld[0]),
    .Tx_Ready(rdy[0]), .Tx(tx[0]), .Tx_Busy(busy[0]), .TxDone(done[0]));
  param_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .Clk(clk), .Reset(rst[1]), .Tx_Data(dat[1]), .Tx_DataValid(vld[1]),
    .Tx_Ready(rdy[1]), .Tx(tx[1]), .Tx_Busy(busy[1]), .TxDone(done[1]));
  param_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .Clk(clk), .Reset(rst[2]), .Tx_Data(dat[2]), .Tx_DataValid(vld[2]),
    .Tx_Ready(rdy[2]), .Tx(tx[2]), .Tx_Busy(busy[2]), .TxDone(done[2]));
  param_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .Clk(clk), .Reset(rst[3]), .Tx_Data(dat7), .Tx_DataValid(vld[3]),
    .Tx_Ready(rdy[3]), .Tx(tx[3]), .Tx_Busy(busy[3]), .TxDone(done[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_dat(input logic [1:0] i, input logic [7:0] d);
    if (i == 2'd3) dat7 = d[6:0];
    else           dat[i] = d;
  endtask

  // Line should sit idle for n cycles.
  task automatic idle(input logic [1:0] i, input int n);
    vld[i] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("u%0d idle_tx", i), tx[i], 1'b1);
      chk($sformatf("u%0d idle_busy", i), busy[i], 1'b0);
      chk($sformatf("u%0d idle_done", i), done[i], 1'b0);
      chk($sformatf("u%0d idle_rdy", i), rdy[i], 1'b1);
    end
  endtask

  // Offer d at a negedge, then follow the frame cycle by cycle. Modes:
  // B2B keeps valid high (data flipped to 0xFF mid-frame, then nxt),
  // PULSE pokes valid while busy, RST resets during data bit 3.
  task automatic frame(input logic [1:0] i, input logic [7:0] d,
                       input int mode, input logic [7:0] nxt);
    logic       q[$];
    logic [7:0] dd;
    int         ones;
    int         len;
    bit         aborted;
    dd = d; ones = 0; aborted = 0;
    q.push_back(1'b0);
    for (int j = 0; j < DB[i]; j++) begin
      q.push_back(dd[0]);
      ones += int'(dd[0]);
      dd = dd >> 1;
    end
    if (PM[i] == 2)      q.push_back((ones % 2) == 1);
    else if (PM[i] == 1) q.push_back((ones % 2) == 0);
    for (int j = 0; j < SB[i]; j++) q.push_back(1'b1);
    len = CPB * q.size();

    chk($sformatf("u%0d rdy_before_accept", i), rdy[i], 1'b1);
    vld[i] = 1'b1;
    set_dat(i, d);
    @(negedge clk);
    for (int k = 0; k < len; k++) begin
      chk($sformatf("u%0d tx k=%0d", i, k), tx[i], q[k / CPB]);
      chk($sformatf("u%0d rdy_low k=%0d", i, k), rdy[i], 1'b0);
      chk($sformatf("u%0d busy k=%0d", i, k), busy[i], 1'b1);
      chk($sformatf("u%0d done_early k=%0d", i, k), done[i], 1'b0);
      if (k == 0 && mode != M_B2B) vld[i] = 1'b0;
      if (mode == M_B2B && k == 3 * CPB) set_dat(i, 8'hFF);
      if (mode == M_B2B && k == len - 2) set_dat(i, nxt);
      if (mode == M_PULSE && k == 5 * CPB) begin
        vld[i] = 1'b1;
        set_dat(i, ~d);
      end
      if (mode == M_PULSE && k == 5 * CPB + 1) vld[i] = 1'b0;
      if (mode == M_RST && k == 4 * CPB + 1) begin
        rst[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("u%0d rst_tx", i), tx[i], 1'b1);
        chk($sformatf("u%0d rst_rdy", i), rdy[i], 1'b1);
        chk($sformatf("u%0d rst_busy", i), busy[i], 1'b0);
        chk($sformatf("u%0d rst_done", i), done[i], 1'b0);
        rst[i] = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk($sformatf("u%0d post_rst_done", i), done[i], 1'b0);
          chk($sformatf("u%0d post_rst_tx", i), tx[i], 1'b1);
          chk($sformatf("u%0d post_rst_busy", i), busy[i], 1'b0);
        end
        aborted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      chk($sformatf("u%0d end_tx", i), tx[i], 1'b1);
      chk($sformatf("u%0d end_done", i), done[i], 1'b1);
      chk($sformatf("u%0d end_rdy", i), rdy[i], 1'b1);
      chk($sformatf("u%0d end_busy", i), busy[i], 1'b0);
    end
  endtask

  // Reset and valid in the same cycle: nothing may be accepted.
  task automatic rst_with_valid(input logic [1:0] i);
    rst[i] = 1'b1;
    vld[i] = 1'b1;
    set_dat(i, 8'hC3);
    @(negedge clk);
    chk($sformatf("u%0d rv_rdy", i), rdy[i], 1'b1);
    chk($sformatf("u%0d rv_busy", i), busy[i], 1'b0);
    chk($sformatf("u%0d rv_tx", i), tx[i], 1'b1);
    rst[i] = 1'b0;
    vld[i] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk($sformatf("u%0d rv_after_busy", i), busy[i], 1'b0);
      chk($sformatf("u%0d rv_after_tx", i), tx[i], 1'b1);
    end
  endtask

  initial begin
    logic [1:0] ri;
    logic [7:0] rd, rd2;
    rst  = '1;
    vld  = '0;
    dat  = '0;
    dat7 = '0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("u%0d reset_tx", n), tx[n[1:0]], 1'b1);
      chk($sformatf("u%0d reset_rdy", n), rdy[n[1:0]], 1'b1);
      chk($sformatf("u%0d reset_busy", n), busy[n[1:0]], 1'b0);
      chk($sformatf("u%0d reset_done", n), done[n[1:0]], 1'b0);
    end
    rst = '0;
    @(negedge clk);

    frame(2'd0, 8'h61, M_NORM, 8'h00); idle(2'd0, 3);
    frame(2'd1, 8'h07, M_NORM, 8'h00); idle(2'd1, 3);
    frame(2'd2, 8'h07, M_NORM, 8'h00); idle(2'd2, 3);
    frame(2'd3, 8'h55, M_NORM, 8'h00); idle(2'd3, 3);

    frame(2'd0, 8'hA5, M_B2B, 8'h3C);
    frame(2'd0, 8'h3C, M_NORM, 8'h00); idle(2'd0, 3);

    frame(2'd0, 8'h00, M_RST, 8'h00);
    frame(2'd0, 8'h81, M_NORM, 8'h00); idle(2'd0, 3);

    frame(2'd1, 8'h5A, M_PULSE, 8'h00); idle(2'd1, 5);
    rst_with_valid(2'd2);

    repeat (16) begin
      ri = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rd2 = 8'($urandom);
        frame(ri, rd, M_B2B, rd2);
        frame(ri, rd2, M_NORM, 8'h00);
      end else begin
        frame(ri, rd, M_NORM, 8'h00);
      end
      idle(ri, $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
